// File: rtl/breakout_pkg.sv
// Shared types and constants for the breakout hit arbiter: FSM state encoding,
// {U,D,L,R} bit positions, default geometry and the per-axis direction resolver.
package breakout_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        OFFER    = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    localparam int DIR_U = 3;
    localparam int DIR_D = 2;
    localparam int DIR_L = 1;
    localparam int DIR_R = 0;

    localparam int NCOL_DEF           = 8;
    localparam int BLOCKS_PER_COL_DEF = 8;

    // Collapse accumulated hits to one direction per axis: U beats D, L beats R.
    function automatic logic [3:0] resolve_dir(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (d[DIR_U]) r[DIR_D] = 1'b0;
        if (d[DIR_L]) r[DIR_R] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/breakout_rr_pick.sv
// Winner selection over the pending-column vector. BREAKOUT_HIT_RR_EN selects a
// round-robin search starting at rr_ptr; otherwise the lowest pending index wins.
module breakout_rr_pick
    import breakout_pkg::*;
#(
    parameter int NCOL  = NCOL_DEF,
    parameter int PTR_W = (NCOL > 1) ? $clog2(NCOL) : 1
) (
    input  logic [NCOL-1:0]  pend,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [PTR_W-1:0] winner,
    output logic             any
);

    assign any = |pend;

`ifdef BREAKOUT_HIT_RR_EN
    // Walk offsets from the far end so the smallest offset from rr_ptr is written last.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] idx_p;
        winner = '0;
        idx    = 0;
        idx_p  = '0;
        for (int k = NCOL - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NCOL) idx = idx - NCOL;
            idx_p = PTR_W'(idx);
            if (pend[idx_p]) winner = idx_p;
        end
    end
`else
    always_comb begin
        logic [PTR_W-1:0] idx_p;
        winner = '0;
        idx_p  = '0;
        for (int k = NCOL - 1; k >= 0; k--) begin
            idx_p = PTR_W'(k);
            if (pend[idx_p]) winner = idx_p;
        end
    end

    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;
`endif

endmodule

// File: rtl/breakout_hit_arbiter.sv
// Latches per-column bounce pulses, grants one column per event, offers the direction
// over valid/ack, then waits out a frame cooldown. Grant policy: BREAKOUT_HIT_RR_EN.
module breakout_hit_arbiter
    import breakout_pkg::*;
#(
    parameter int NCOL            = NCOL_DEF,
    parameter int CNT_W           = 5,
    parameter int BLOCKS_PER_COL  = BLOCKS_PER_COL_DEF,
    parameter int SCORE_W         = 10,
    parameter int COOLDOWN_FRAMES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic [4*NCOL-1:0]        col_dir,
    input  logic [CNT_W*NCOL-1:0]    col_count,
    input  logic                     ball_ack,
    output logic                     redir_valid,
    output logic [3:0]               redir_dir,
    output logic [$clog2(NCOL)-1:0]  redir_col,
    output logic [SCORE_W-1:0]       score,
    output logic                     board_clear,
    output logic                     busy
);

    localparam int PTR_W = $clog2(NCOL);
    localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    state_t             state_reg, state_next;
    logic [NCOL-1:0]    pend_vec;
    logic [4*NCOL-1:0]  dir_lat_flat;
    logic [PTR_W-1:0]   rr_ptr_reg;
    logic [CD_W-1:0]    cd_cnt_reg;
    logic [PTR_W-1:0]   redir_col_reg;
    logic [3:0]         redir_dir_reg;
    logic [SCORE_W-1:0] score_reg, sum_next;
    logic               board_clear_reg;
    logic [PTR_W-1:0]   win_idx;
    logic               win_any;
    logic [3:0]         win_dir;
    logic               cap_en, ack_fire;

    assign cap_en   = (state_reg != COOLDOWN);
    assign ack_fire = (state_reg == OFFER) && ball_ack;

    // An ack wipes every column, so hits arriving in the ack cycle are dropped too.
    for (genvar gi = 0; gi < NCOL; gi++) begin : g_col
        logic       pend_reg;
        logic [3:0] dir_lat_reg;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pend_reg    <= 1'b0;
                dir_lat_reg <= 4'b0;
            end else if (ack_fire) begin
                pend_reg    <= 1'b0;
                dir_lat_reg <= 4'b0;
            end else if (cap_en && (col_dir[4*gi +: 4] != 4'b0)) begin
                pend_reg    <= 1'b1;
                dir_lat_reg <= dir_lat_reg | col_dir[4*gi +: 4];
            end
        end
        assign pend_vec[gi]            = pend_reg;
        assign dir_lat_flat[4*gi +: 4] = dir_lat_reg;
    end

    breakout_rr_pick #(.NCOL(NCOL), .PTR_W(PTR_W)) u_pick (
        .pend   (pend_vec),
        .rr_ptr (rr_ptr_reg),
        .winner (win_idx),
        .any    (win_any)
    );

    assign win_dir = dir_lat_flat[{win_idx, 2'b00} +: 4];

    // IDLE also looks at the live inputs so a fresh hit reaches GRANT one cycle sooner.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:     if (pend_vec != '0 || col_dir != '0) state_next = GRANT;
            GRANT:    state_next = win_any ? OFFER : IDLE;
            OFFER:    if (ball_ack) state_next = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
            COOLDOWN: if (frame_tick && cd_cnt_reg == CD_W'(COOLDOWN_FRAMES - 1))
                          state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        sum_next = '0;
        for (int c = 0; c < NCOL; c++)
            sum_next = sum_next + SCORE_W'(col_count[CNT_W*c +: CNT_W]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_reg      <= '0;
            cd_cnt_reg      <= '0;
            redir_col_reg   <= '0;
            redir_dir_reg   <= 4'b0;
            score_reg       <= '0;
            board_clear_reg <= 1'b0;
        end else begin
            if (state_reg == GRANT) begin
                redir_col_reg <= win_idx;
                redir_dir_reg <= resolve_dir(win_dir);
            end
            if (ack_fire) begin
                rr_ptr_reg <= (redir_col_reg == PTR_W'(NCOL - 1)) ? '0 : redir_col_reg + 1'b1;
                cd_cnt_reg <= '0;
            end else if (state_reg == COOLDOWN && frame_tick) begin
                cd_cnt_reg <= cd_cnt_reg + 1'b1;
            end
            score_reg       <= sum_next;
            board_clear_reg <= (score_reg == SCORE_W'(NCOL * BLOCKS_PER_COL));
        end
    end

    assign redir_valid = (state_reg == OFFER);
    assign redir_dir   = redir_dir_reg;
    assign redir_col   = redir_col_reg;
    assign score       = score_reg;
    assign board_clear = board_clear_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_breakout_hit_arbiter.sv
// Randomized bench for breakout_hit_arbiter against a transaction-level model of the
// grant policy, direction resolution, cooldown and score. Honors BREAKOUT_HIT_RR_EN.
module tb_breakout_hit_arbiter;

    localparam int NCOL            = 8;
    localparam int CNT_W           = 5;
    localparam int BLOCKS_PER_COL  = 8;
    localparam int SCORE_W         = 10;
    localparam int COOLDOWN_FRAMES = 2;
    localparam int PTR_W           = $clog2(NCOL);

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    frame_tick;
    logic [4*NCOL-1:0]       col_dir;
    logic [CNT_W*NCOL-1:0]   col_count;
    logic                    ball_ack;
    logic                    redir_valid;
    logic [3:0]              redir_dir;
    logic [PTR_W-1:0]        redir_col;
    logic [SCORE_W-1:0]      score;
    logic                    board_clear;
    logic                    busy;

    int n_checks = 0;
    int n_errors = 0;
    int rr_model = 0;
    int prev_sum = 0;

    breakout_hit_arbiter #(
        .NCOL(NCOL), .CNT_W(CNT_W), .BLOCKS_PER_COL(BLOCKS_PER_COL),
        .SCORE_W(SCORE_W), .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .col_dir(col_dir),
        .col_count(col_count), .ball_ack(ball_ack), .redir_valid(redir_valid),
        .redir_dir(redir_dir), .redir_col(redir_col), .score(score),
        .board_clear(board_clear), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [NCOL-1:0] p);
`ifdef BREAKOUT_HIT_RR_EN
        for (int k = 0; k < NCOL; k++)
            if (p[(rr_model + k) % NCOL]) return (rr_model + k) % NCOL;
`else
        for (int k = 0; k < NCOL; k++)
            if (p[k]) return k;
`endif
        return 0;
    endfunction

    function automatic logic [3:0] resolve(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (d[3]) r[2] = 1'b0;
        if (d[1]) r[0] = 1'b0;
        return r;
    endfunction

    // One full bounce event: pulse, grant, hold, ack, cooldown, back to idle.
    task automatic run_hit(input logic [4*NCOL-1:0] dirs, input int hold,
                           input logic [4*NCOL-1:0] ack_dirs);
        logic [NCOL-1:0] p;
        logic [3:0]      ed;
        int              w;
        int              ticks;
        int              iter;
        for (int c = 0; c < NCOL; c++) p[c] = (dirs[4*c +: 4] != 4'b0);
        w  = pick(p);
        ed = resolve(dirs[4*w +: 4]);

        col_dir    = dirs;
        ball_ack   = 1'($urandom_range(0, 1));
        frame_tick = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("idle_valid", redir_valid, 0);
        @(posedge clk); #1;
        col_dir  = '0;
        ball_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("grant_busy", busy, 1);
        check("grant_valid", redir_valid, 0);
        @(posedge clk); #1;
        ball_ack = 1'b0;
        for (int h = 0; h < hold; h++) begin
            col_dir    = $urandom;
            frame_tick = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_valid", redir_valid, 1);
            check("hold_col", redir_col, w);
            check("hold_dir", redir_dir, ed);
            @(posedge clk); #1;
        end
        ball_ack   = 1'b1;
        col_dir    = ack_dirs;
        frame_tick = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("offer_valid", redir_valid, 1);
        check("offer_col", redir_col, w);
        check("offer_dir", redir_dir, ed);
        @(posedge clk); #1;
        ball_ack = 1'b0;
        rr_model = (w + 1) % NCOL;

        ticks = 0;
        iter  = 0;
        while (ticks < COOLDOWN_FRAMES) begin
            frame_tick = (iter > 20) || ($urandom_range(0, 2) == 0);
            col_dir    = $urandom;
            @(negedge clk);
            check("cd_valid", redir_valid, 0);
            check("cd_busy", busy, 1);
            @(posedge clk); #1;
            if (frame_tick) ticks++;
            iter++;
        end
        frame_tick = 1'b0;
        col_dir    = '0;
        @(negedge clk);
        check("post_cd_busy", busy, 0);
        check("post_cd_valid", redir_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("drop_busy", busy, 0);
        @(posedge clk); #1;
        $display("hit: dirs=%08h hold=%0d -> col=%0d dir=%b (cooldown %0d cycles)",
                 dirs, hold, w, ed, iter);
    endtask

    task automatic run_score(input logic [CNT_W*NCOL-1:0] cc);
        int sum;
        sum = 0;
        for (int c = 0; c < NCOL; c++) sum += int'(cc[CNT_W*c +: CNT_W]);
        col_count = cc;
        @(posedge clk); #1;
        @(negedge clk);
        check("score", score, sum);
        check("clear_lag", board_clear, (prev_sum == NCOL * BLOCKS_PER_COL));
        @(posedge clk); #1;
        @(negedge clk);
        check("clear", board_clear, (sum == NCOL * BLOCKS_PER_COL));
        prev_sum = sum;
        $display("score: counts=%010h -> score=%0d board_clear=%0d", cc, sum,
                 (sum == NCOL * BLOCKS_PER_COL));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4*NCOL-1:0]     dirs;
        logic [CNT_W*NCOL-1:0] cc;
        logic [NCOL-1:0]       mask;

        reset = 1'b1; frame_tick = 1'b0; col_dir = '0; col_count = '0; ball_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", redir_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_score", score, 0);
        check("rst_clear", board_clear, 0);
        check("rst_col", redir_col, 0);
        check("rst_dir", redir_dir, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Columns 1 and 5 together, twice: policy decides the second grant.
        dirs = '0; dirs[4*1 +: 4] = 4'b1000; dirs[4*5 +: 4] = 4'b0010;
        run_hit(dirs, 1, '0);
        run_hit(dirs, 1, '0);
        // Single down-hit on column 2, held five cycles before ack.
        dirs = '0; dirs[4*2 +: 4] = 4'b0100;
        run_hit(dirs, 5, '0);
        // All four directions on one column; column 3 hit during the ack cycle.
        dirs = '0; dirs[4*6 +: 4] = 4'b1111;
        cc   = '0;
        run_hit(dirs, 2, {20'h0, 4'b0001, 12'h0});

        for (int n = 0; n < 30; n++) begin
            mask = NCOL'($urandom_range(1, (1 << NCOL) - 1));
            dirs = '0;
            for (int c = 0; c < NCOL; c++)
                if (mask[c]) dirs[4*c +: 4] = 4'($urandom_range(1, 15));
            run_hit(dirs, $urandom_range(0, 5), $urandom);
        end

        for (int c = 0; c < NCOL; c++) cc[CNT_W*c +: CNT_W] = CNT_W'(BLOCKS_PER_COL);
        run_score(cc);
        run_score('0);
        for (int n = 0; n < 8; n++) begin
            for (int c = 0; c < NCOL; c++) cc[CNT_W*c +: CNT_W] = CNT_W'($urandom_range(0, 31));
            run_score(cc);
        end
        for (int c = 0; c < NCOL; c++) cc[CNT_W*c +: CNT_W] = CNT_W'(BLOCKS_PER_COL);
        run_score(cc);

        // Reset asserted in the middle of an offer.
        dirs = '0; dirs[4*4 +: 4] = 4'b0010;
        col_dir = dirs;
        @(posedge clk); #1;
        col_dir = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_valid", redir_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", redir_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_score", score, 0);
        check("async_rst_clear", board_clear, 0);
        $display("reset: asserted during offer, outputs cleared");
        @(posedge clk); #1;
        col_count = '0;
        reset     = 1'b0;
        rr_model  = 0;
        prev_sum  = 0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        @(posedge clk); #1;

        dirs = '0; dirs[4*1 +: 4] = 4'b0001; dirs[4*5 +: 4] = 4'b0100;
        run_hit(dirs, 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
